// File: rtl/fifo_word_serializer.sv
// fifo_word_serializer
//   Read-side drain stage for a word FIFO. Pops one WORD_W word at a time
//   (RD/EMPTY/data_out handshake) and emits it as LANES = WORD_W/OUT_W beats
//   on a valid/ready stream. Only one FIFO read is ever outstanding, and the
//   next word is requested only after the current word has fully drained.
//
// Ports
//   clk         rising-edge clock, shared with the FIFO
//   reset       synchronous active-low reset
//   en          permits starting new FIFO reads (a word in flight always completes)
//   fifo_empty  FIFO EMPTY flag
//   fifo_rd     FIFO RD strobe, one cycle per word
//   fifo_data   FIFO data_out, valid the cycle after fifo_rd
//   out_data    current beat
//   out_valid   beat valid
//   out_ready   sink accepts beat
//   out_last    final beat of the word
//   busy        FSM not idle
//   word_count  fully transmitted words, wraps modulo 2^CNT_W
module fifo_word_serializer #(
  parameter int WORD_W    = 32,
  parameter int OUT_W     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  input  logic [WORD_W-1:0] fifo_data,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic [CNT_W-1:0]  word_count
);

  localparam int LANES = WORD_W / OUT_W;
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_SEND
  } state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [WORD_W-1:0] shift_q;
  logic [CNT_W-1:0]  count_q;

  logic last_lane;
  assign last_lane = (idx_q == LAST_IDX);

  // The word is shifted toward the output lane after each accepted beat, so
  // the beat is always taken from a fixed slice instead of a lane mux.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      shift_q <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en && !fifo_empty) state_q <= ST_REQ;
        end
        ST_REQ: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          shift_q <= fifo_data;
          idx_q   <= '0;
          state_q <= ST_SEND;
        end
        ST_SEND: begin
          if (out_ready) begin
            if (last_lane) begin
              count_q <= count_q + 1'b1;
              state_q <= (en && !fifo_empty) ? ST_REQ : ST_IDLE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              shift_q <= MSB_FIRST ? (shift_q << OUT_W) : (shift_q >> OUT_W);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign fifo_rd    = (state_q == ST_REQ);
  assign out_valid  = (state_q == ST_SEND);
  assign out_last   = (state_q == ST_SEND) && last_lane;
  assign busy       = (state_q != ST_IDLE);
  assign word_count = count_q;
  assign out_data   = MSB_FIRST ? shift_q[WORD_W-1 -: OUT_W] : shift_q[OUT_W-1:0];

endmodule

// File: tb/tb_fifo_word_serializer.sv
module tb_fifo_word_serializer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic        out_ready;
  logic [31:0] fifo_data = '0;
  logic        fifo_empty;

  logic        m_rd, m_valid, m_last, m_busy;
  logic [7:0]  m_data;
  logic [15:0] m_wc;
  logic        l_rd, l_valid, l_last, l_busy;
  logic [7:0]  l_data;
  logic [15:0] l_wc;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fifo_word_serializer #(.WORD_W(32), .OUT_W(8), .MSB_FIRST(1'b1), .CNT_W(16)) u_msb (
    .clk(clk), .reset(reset_n), .en(en), .fifo_empty(fifo_empty), .fifo_rd(m_rd),
    .fifo_data(fifo_data), .out_data(m_data), .out_valid(m_valid), .out_ready(out_ready),
    .out_last(m_last), .busy(m_busy), .word_count(m_wc)
  );

  fifo_word_serializer #(.WORD_W(32), .OUT_W(8), .MSB_FIRST(1'b0), .CNT_W(16)) u_lsb (
    .clk(clk), .reset(reset_n), .en(en), .fifo_empty(fifo_empty), .fifo_rd(l_rd),
    .fifo_data(fifo_data), .out_data(l_data), .out_valid(l_valid), .out_ready(out_ready),
    .out_last(l_last), .busy(l_busy), .word_count(l_wc)
  );

  // FIFO model: registered data_out, popped by the RD strobe.
  logic [31:0] mem [0:63];
  int wr_cnt = 0;
  int rd_cnt = 0;
  assign fifo_empty = (wr_cnt == rd_cnt);

  always @(posedge clk) begin
    if (m_rd && (rd_cnt != wr_cnt)) begin
      fifo_data <= mem[rd_cnt % 64];
      rd_cnt    <= rd_cnt + 1;
    end
  end

  // Scoreboards of {last, beat}.
  logic [8:0] exp_m [$];
  logic [8:0] exp_l [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_word(input logic [31:0] w);
    mem[wr_cnt % 64] = w;
    wr_cnt = wr_cnt + 1;
    for (int unsigned i = 0; i < 4; i++) begin
      exp_m.push_back({(i == 3), w[8*(3-i) +: 8]});
      exp_l.push_back({(i == 3), w[8*i +: 8]});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rd();
    int n = 0;
    while (!m_rd && n < 30) begin
      tick();
      n++;
    end
    check("rd_seen", {31'd0, m_rd}, 32'd1);
  endtask

  task automatic wait_wc(input logic [15:0] want);
    int n = 0;
    while (m_wc !== want && n < 60) begin
      tick();
      n++;
    end
    check("word_count", {16'd0, m_wc}, {16'd0, want});
  endtask

  // Monitor: compare every handshake against the scoreboard, and verify
  // that a stalled beat is held.
  logic       stall_q = 1'b0;
  logic [8:0] held_q  = '0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (stall_q) begin
        check("hold_valid", {31'd0, m_valid}, 32'd1);
        check("hold_beat", {23'd0, m_last, m_data}, {23'd0, held_q});
      end
      if (m_valid && out_ready) begin
        if (exp_m.size() == 0) begin
          check("unexpected_beat", 32'd1, 32'd0);
        end else begin
          check("msb_beat", {23'd0, m_last, m_data}, {23'd0, exp_m.pop_front()});
          check("lsb_valid", {31'd0, l_valid}, 32'd1);
          check("lsb_beat", {23'd0, l_last, l_data}, {23'd0, exp_l.pop_front()});
        end
      end
    end
    stall_q <= reset_n && m_valid && !out_ready;
    held_q  <= {m_last, m_data};
  end

  initial begin
    en        = 1'b1;
    out_ready = 1'b1;
    reset_n   = 1'b0;

    // Reset with a word already waiting in the FIFO.
    push_word(32'hA1B2C3D4);
    tick();
    tick();
    check("rst_rd", {31'd0, m_rd}, 32'd0);
    check("rst_valid", {31'd0, m_valid}, 32'd0);
    check("rst_last", {31'd0, m_last}, 32'd0);
    check("rst_busy", {31'd0, m_busy}, 32'd0);
    check("rst_wc", {16'd0, m_wc}, 32'd0);
    check("rst_data", {24'd0, m_data}, 32'd0);
    check("rst_lsb_data", {24'd0, l_data}, 32'd0);
    reset_n = 1'b1;
    tick();
    check("rd_after_rst", {31'd0, m_rd}, 32'd1);
    tick();
    check("wait_rd", {31'd0, m_rd}, 32'd0);
    check("wait_valid", {31'd0, m_valid}, 32'd0);
    tick();
    check("first_beat_valid", {31'd0, m_valid}, 32'd1);
    check("first_beat", {24'd0, m_data}, 32'hA1);
    repeat (4) tick();
    check("idle_busy", {31'd0, m_busy}, 32'd0);
    check("idle_valid", {31'd0, m_valid}, 32'd0);
    check("wc1", {16'd0, m_wc}, 32'd1);
    check("lsb_wc1", {16'd0, l_wc}, 32'd1);

    // Backpressure on beat B2.
    push_word(32'hA1B2C3D4);
    wait_rd();
    tick();
    tick();
    tick();
    check("bp_b2", {24'd0, m_data}, 32'hB2);
    out_ready = 1'b0;
    repeat (3) begin
      tick();
      check("bp_no_rd", {31'd0, m_rd}, 32'd0);
      check("bp_hold", {24'd0, m_data}, 32'hB2);
    end
    out_ready = 1'b1;
    tick();
    check("bp_c3", {24'd0, m_data}, 32'hC3);
    wait_wc(16'd2);

    // Back-to-back words: 2-cycle bubble.
    push_word(32'h11223344);
    push_word(32'h55667788);
    wait_rd();
    tick();
    tick();
    check("b2b_11", {24'd0, m_data}, 32'h11);
    repeat (3) tick();
    check("b2b_44", {24'd0, m_data}, 32'h44);
    check("b2b_44_last", {31'd0, m_last}, 32'd1);
    tick();
    check("b2b_rd2", {31'd0, m_rd}, 32'd1);
    check("b2b_bub1", {31'd0, m_valid}, 32'd0);
    tick();
    check("b2b_bub2", {31'd0, m_valid}, 32'd0);
    tick();
    check("b2b_55", {24'd0, m_data}, 32'h55);
    wait_wc(16'd4);

    // en dropped during beat 22: word completes, no further read.
    push_word(32'h11223344);
    push_word(32'h55667788);
    wait_rd();
    tick();
    tick();
    tick();
    check("en_22", {24'd0, m_data}, 32'h22);
    en = 1'b0;
    repeat (3) tick();
    check("en_idle", {31'd0, m_busy}, 32'd0);
    check("en_wc", {16'd0, m_wc}, 32'd5);
    repeat (4) begin
      tick();
      check("en_no_rd", {31'd0, m_rd}, 32'd0);
    end
    en = 1'b1;
    wait_rd();
    wait_wc(16'd6);

    // Reset while beat C3 is presented.
    push_word(32'hA1B2C3D4);
    wait_rd();
    repeat (4) tick();
    check("rst_mid_c3", {24'd0, m_data}, 32'hC3);
    reset_n = 1'b0;
    tick();
    check("rst_mid_valid", {31'd0, m_valid}, 32'd0);
    check("rst_mid_wc", {16'd0, m_wc}, 32'd0);
    check("rst_mid_busy", {31'd0, m_busy}, 32'd0);
    exp_m.delete();
    exp_l.delete();
    reset_n = 1'b1;
    push_word(32'hDEADBEEF);
    wait_rd();
    tick();
    tick();
    check("restart_de", {24'd0, m_data}, 32'hDE);
    check("restart_lsb_ef", {24'd0, l_data}, 32'hEF);
    wait_wc(16'd1);
    tick();
    check("sb_empty", exp_m.size(), 32'd0);
    check("sb_lsb_empty", exp_l.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
